// File: rtl/core85_pkg.sv
// Shared definitions for the 8085 bus interface: FSM encodings, wait-count width
// and the default interrupt-acknowledge opcode.
package core85_pkg;

   localparam int         WAIT_W      = 4;
   localparam logic [7:0] RST7_OPCODE = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_STROBE = 3'd1,
      ST_WAIT   = 3'd2,
      ST_XFER   = 3'd3,
      ST_DONE   = 3'd4
   } bus_state_t;

   function automatic logic [WAIT_W-1:0] sel_wait(
      input logic              is_io,
      input logic [WAIT_W-1:0] wait_mem,
      input logic [WAIT_W-1:0] wait_io
   );
      return is_io ? wait_io : wait_mem;
   endfunction

endpackage

// File: rtl/waitgen85.sv
// Loadable down-counter that times READY wait states; saturates at zero.
module waitgen85
   import core85_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic [WAIT_W-1:0] i_value,
   input  logic              i_dec,
   output logic              o_zero
);

   logic [WAIT_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/bus85.sv
// 8085 bus interface unit: ALE demux, strobe-to-request conversion, READY wait states.
// Optional macro BUS85_INTA_VEC_EN: drive INTA_VECTOR during interrupt acknowledge.
module bus85
   import core85_pkg::*;
#(
   parameter int         WAIT_MEM    = 1,
   parameter int         WAIT_IO     = 2,
   parameter logic [7:0] INTA_VECTOR = RST7_OPCODE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  ad_i,
   output logic [7:0]  ad_o,
   output logic        ad_oe,
   input  logic [7:0]  addrhigh,
   input  logic        ale,
   input  logic        rd_,
   input  logic        wr_,
   input  logic        iom_,
   input  logic        inta_,
   input  logic        hlda,
   output logic        ready,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [7:0]  mem_rdata,
   output logic [7:0]  io_addr,
   output logic [7:0]  io_wdata,
   output logic        io_rd,
   output logic        io_wr,
   input  logic [7:0]  io_rdata,
   output logic        err,
   output bus_state_t  dbg_state
);

   localparam logic [WAIT_W-1:0] LP_WAIT_MEM = WAIT_W'(WAIT_MEM);
   localparam logic [WAIT_W-1:0] LP_WAIT_IO  = WAIT_W'(WAIT_IO);

   bus_state_t  r_state;
   logic [15:0] r_addr_q;
   logic        r_iom_q;
   logic [7:0]  r_wdata;
   logic [7:0]  r_rdata;
   logic        r_cap_pend;
   logic        r_is_io;
   logic        r_is_rd;
   logic        r_inta;
   logic        r_ready;
   logic        r_ad_oe;
   logic        r_mem_rd;
   logic        r_mem_wr;
   logic        r_io_rd;
   logic        r_io_wr;
   logic        r_err;

   logic              w_strobes_high;
   logic [7:0]        w_port_rdata;
   logic              w_cnt_load;
   logic              w_cnt_dec;
   logic              w_cnt_zero;
   logic [WAIT_W-1:0] w_wait_sel;

   assign w_strobes_high = rd_ & wr_;
   assign w_port_rdata   = r_is_io ? io_rdata : mem_rdata;
   assign w_wait_sel     = sel_wait(r_iom_q, LP_WAIT_MEM, LP_WAIT_IO);
   // The counter is reloaded every idle cycle, so it holds N when the strobe is seen.
   assign w_cnt_load     = (r_state == ST_IDLE);
   assign w_cnt_dec      = ((r_state == ST_STROBE) || (r_state == ST_WAIT)) && !w_cnt_zero;

   waitgen85 u_waitgen (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_load  (w_cnt_load),
      .i_value (w_wait_sel),
      .i_dec   (w_cnt_dec),
      .o_zero  (w_cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_addr_q   <= '0;
         r_iom_q    <= 1'b0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_cap_pend <= 1'b0;
         r_is_io    <= 1'b0;
         r_is_rd    <= 1'b0;
         r_inta     <= 1'b0;
         r_ready    <= 1'b1;
         r_ad_oe    <= 1'b0;
         r_mem_rd   <= 1'b0;
         r_mem_wr   <= 1'b0;
         r_io_rd    <= 1'b0;
         r_io_wr    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         if (ale) begin
            r_addr_q <= {addrhigh, ad_i};
            r_iom_q  <= iom_;
            if (r_state != ST_IDLE) begin
               r_err <= 1'b1;
            end
         end

         // Port read data is valid the cycle after the request; grab it once.
         if (r_cap_pend) begin
            r_rdata    <= w_port_rdata;
            r_cap_pend <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (!hlda) begin
                  if (!rd_ && !wr_) begin
                     r_err   <= 1'b1;
                     r_state <= ST_DONE;
                  end else if (!rd_ && !inta_) begin
`ifdef BUS85_INTA_VEC_EN
                     r_inta  <= 1'b1;
                     r_ad_oe <= 1'b1;
                     r_state <= ST_XFER;
`endif
                  end else if (!rd_) begin
                     r_is_rd  <= 1'b1;
                     r_is_io  <= r_iom_q;
                     r_io_rd  <= r_iom_q;
                     r_mem_rd <= !r_iom_q;
                     r_state  <= ST_STROBE;
                  end else if (!wr_) begin
                     r_is_rd  <= 1'b0;
                     r_is_io  <= r_iom_q;
                     r_wdata  <= ad_i;
                     r_io_wr  <= r_iom_q;
                     r_mem_wr <= !r_iom_q;
                     r_state  <= ST_STROBE;
                  end
               end
            end

            ST_STROBE: begin
               r_mem_rd   <= 1'b0;
               r_mem_wr   <= 1'b0;
               r_io_rd    <= 1'b0;
               r_io_wr    <= 1'b0;
               r_cap_pend <= r_is_rd;
               if (!w_cnt_zero) begin
                  r_ready <= 1'b0;
                  r_state <= ST_WAIT;
               end else begin
                  r_ad_oe <= r_is_rd;
                  r_state <= ST_XFER;
               end
            end

            ST_WAIT: begin
               if (w_strobes_high) begin
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
               end else if (w_cnt_zero) begin
                  r_ready <= 1'b1;
                  r_ad_oe <= r_is_rd;
                  r_state <= ST_XFER;
               end
            end

            ST_XFER: begin
               if (w_strobes_high) begin
                  r_ad_oe <= 1'b0;
                  r_inta  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end

            ST_DONE: begin
               if (w_strobes_high) begin
                  r_state <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // With no wait states the drive starts before the capture edge, so pass the port through.
   assign ad_o = !r_ad_oe   ? 8'h00 :
                 r_inta     ? INTA_VECTOR :
                 r_cap_pend ? w_port_rdata :
                              r_rdata;

   assign ad_oe     = r_ad_oe;
   assign ready     = r_ready;
   assign mem_addr  = r_addr_q;
   assign io_addr   = r_addr_q[7:0];
   assign mem_wdata = r_wdata;
   assign io_wdata  = r_wdata;
   assign mem_rd    = r_mem_rd;
   assign mem_wr    = r_mem_wr;
   assign io_rd     = r_io_rd;
   assign io_wr     = r_io_wr;
   assign err       = r_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_bus85.sv
// Directed bench for bus85: unit A uses default waits, unit B uses WAIT_MEM=0, WAIT_IO=5.
module tb_bus85;
   import core85_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] ad_i, addrhigh, mem_rdata, io_rdata;
   logic       ale, rd_, wr_, iom_, inta_, hlda;

   logic [7:0]  a_ad_o, a_mem_wdata, a_io_addr, a_io_wdata;
   logic [15:0] a_mem_addr;
   logic        a_ad_oe, a_ready, a_mem_rd, a_mem_wr, a_io_rd, a_io_wr, a_err;
   bus_state_t  a_state;
   logic [7:0]  b_ad_o, b_mem_wdata, b_io_addr, b_io_wdata;
   logic [15:0] b_mem_addr;
   logic        b_ad_oe, b_ready, b_mem_rd, b_mem_wr, b_io_rd, b_io_wr, b_err;
   bus_state_t  b_state;

   int n_assert = 0;
   int n_fail   = 0;
   int a_cnt[4];
   int b_cnt[4];
   int snap_a[4];
   int snap_b[4];

   bus85 u_dut_a (
      .clk(clk), .rst(rst), .ad_i(ad_i), .ad_o(a_ad_o), .ad_oe(a_ad_oe),
      .addrhigh(addrhigh), .ale(ale), .rd_(rd_), .wr_(wr_), .iom_(iom_),
      .inta_(inta_), .hlda(hlda), .ready(a_ready), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr),
      .mem_rdata(mem_rdata), .io_addr(a_io_addr), .io_wdata(a_io_wdata),
      .io_rd(a_io_rd), .io_wr(a_io_wr), .io_rdata(io_rdata), .err(a_err),
      .dbg_state(a_state)
   );

   bus85 #(.WAIT_MEM(0), .WAIT_IO(5)) u_dut_b (
      .clk(clk), .rst(rst), .ad_i(ad_i), .ad_o(b_ad_o), .ad_oe(b_ad_oe),
      .addrhigh(addrhigh), .ale(ale), .rd_(rd_), .wr_(wr_), .iom_(iom_),
      .inta_(inta_), .hlda(hlda), .ready(b_ready), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
      .mem_rdata(mem_rdata), .io_addr(b_io_addr), .io_wdata(b_io_wdata),
      .io_rd(b_io_rd), .io_wr(b_io_wr), .io_rdata(io_rdata), .err(b_err),
      .dbg_state(b_state)
   );

   // Request pulses, counted away from the active edge: [0]=mem_rd [1]=mem_wr [2]=io_rd [3]=io_wr
   initial begin
      for (int i = 0; i < 4; i++) begin
         a_cnt[i] = 0;
         b_cnt[i] = 0;
      end
   end
   always @(negedge clk) begin
      if (a_mem_rd) a_cnt[0]++;
      if (a_mem_wr) a_cnt[1]++;
      if (a_io_rd)  a_cnt[2]++;
      if (a_io_wr)  a_cnt[3]++;
      if (b_mem_rd) b_cnt[0]++;
      if (b_mem_wr) b_cnt[1]++;
      if (b_io_rd)  b_cnt[2]++;
      if (b_io_wr)  b_cnt[3]++;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic snap();
      for (int i = 0; i < 4; i++) begin
         snap_a[i] = a_cnt[i];
         snap_b[i] = b_cnt[i];
      end
   endtask

   function automatic logic [15:0] da(input int idx);
      return 16'(a_cnt[idx] - snap_a[idx]);
   endfunction

   function automatic logic [15:0] db(input int idx);
      return 16'(b_cnt[idx] - snap_b[idx]);
   endfunction

   function automatic logic [3:0] a_stb();
      return {a_mem_rd, a_mem_wr, a_io_rd, a_io_wr};
   endfunction

   function automatic logic [3:0] b_stb();
      return {b_mem_rd, b_mem_wr, b_io_rd, b_io_wr};
   endfunction

   initial begin
      rst = 1'b1; ad_i = 8'h00; addrhigh = 8'h00; ale = 1'b0; rd_ = 1'b1; wr_ = 1'b1;
      iom_ = 1'b0; inta_ = 1'b1; hlda = 1'b0; mem_rdata = 8'hA5; io_rdata = 8'h3C;
      step();
      step();

      // Reset values
      chk("rst_ready",   16'(a_ready),     16'h1);
      chk("rst_ad_oe",   16'(a_ad_oe),     16'h0);
      chk("rst_ad_o",    16'(a_ad_o),      16'h0);
      chk("rst_strobes", 16'(a_stb()),     16'h0);
      chk("rst_err",     16'(a_err),       16'h0);
      chk("rst_mem_addr", a_mem_addr,      16'h0000);
      chk("rst_io_addr", 16'(a_io_addr),   16'h0);
      chk("rst_wdata",   {a_mem_wdata, a_io_wdata}, 16'h0000);
      chk("rst_state",   16'(a_state),     16'(ST_IDLE));
      rst = 1'b0;
      step();

      // 1: memory read at 1234, WAIT_MEM=1
      ale = 1'b1; addrhigh = 8'h12; ad_i = 8'h34; iom_ = 1'b0;
      step();
      ale = 1'b0; ad_i = 8'h00;
      chk("t1_mem_addr", a_mem_addr, 16'h1234);
      snap();
      rd_ = 1'b0;
      step();
      chk("t1_c1_strobe", 16'(a_stb()), 16'b1000);
      chk("t1_c1_ready",  16'(a_ready), 16'h1);
      step();
      chk("t1_c2_strobe", 16'(a_stb()), 16'h0);
      chk("t1_c2_ready",  16'(a_ready), 16'h0);
      chk("t1_c2_ad_oe",  16'(a_ad_oe), 16'h0);
      step();
      chk("t1_c3_ready",  16'(a_ready), 16'h1);
      chk("t1_c3_ad_oe",  16'(a_ad_oe), 16'h1);
      chk("t1_c3_ad_o",   16'(a_ad_o),  16'hA5);
      step();
      chk("t1_c4_ad_o",   16'(a_ad_o),  16'hA5);
      rd_ = 1'b1;
      step();
      chk("t1_oe_drop",   16'(a_ad_oe), 16'h0);
      chk("t1_state",     16'(a_state), 16'(ST_IDLE));
      chk("t1_pulses",    {da(0), da(1), da(2), da(3)} == 64'h0001_0000_0000_0000 ? 16'h1 : 16'h0, 16'h1);

      // 2: I/O write of 5A to port 80, WAIT_IO=2 (unit B aborts its 5-cycle wait early)
      ale = 1'b1; addrhigh = 8'h00; ad_i = 8'h80; iom_ = 1'b1;
      step();
      ale = 1'b0; ad_i = 8'h5A;
      snap();
      wr_ = 1'b0;
      step();
      chk("t2_c1_strobe", 16'(a_stb()),     16'b0001);
      chk("t2_io_addr",   16'(a_io_addr),   16'h80);
      chk("t2_io_wdata",  16'(a_io_wdata),  16'h5A);
      step();
      chk("t2_c2_ready",  16'(a_ready), 16'h0);
      step();
      chk("t2_c3_ready",  16'(a_ready), 16'h0);
      step();
      chk("t2_c4_ready",  16'(a_ready), 16'h1);
      chk("t2_c4_state",  16'(a_state), 16'(ST_XFER));
      chk("t2_c4_ad_oe",  16'(a_ad_oe), 16'h0);
      wr_ = 1'b1;
      step();
      chk("t2_state",     16'(a_state), 16'(ST_IDLE));
      chk("t2_io_wr_n",   da(3), 16'h1);
      chk("t2_mem_quiet", da(0) + da(1), 16'h0);
      chk("t2_b_abort_st", 16'(b_state), 16'(ST_IDLE));
      chk("t2_b_abort_rdy", 16'(b_ready), 16'h1);
      step();
      chk("t2_b_one_req", db(3), 16'h1);

      // 3: zero-wait memory read on unit B
      ale = 1'b1; addrhigh = 8'h20; ad_i = 8'h00; iom_ = 1'b0; mem_rdata = 8'h5C;
      step();
      ale = 1'b0;
      rd_ = 1'b0;
      step();
      chk("t3_c1_strobe", 16'(b_stb()),  16'b1000);
      chk("t3_c1_ready",  16'(b_ready),  16'h1);
      step();
      chk("t3_c2_ready",  16'(b_ready),  16'h1);
      chk("t3_c2_ad_oe",  16'(b_ad_oe),  16'h1);
      chk("t3_c2_ad_o",   16'(b_ad_o),   16'h5C);
      step();
      chk("t3_c3_ad_o",   16'(b_ad_o),   16'h5C);
      chk("t3_c3_ready",  16'(b_ready),  16'h1);
      rd_ = 1'b1;
      step();
      chk("t3_oe_drop",   16'(b_ad_oe),  16'h0);

      // 4: RD_ and WR_ together
      snap();
      rd_ = 1'b0; wr_ = 1'b0;
      step();
      chk("t4_err",       16'(a_err),   16'h1);
      chk("t4_strobe",    16'(a_stb()), 16'h0);
      chk("t4_state",     16'(a_state), 16'(ST_DONE));
      rd_ = 1'b1; wr_ = 1'b1;
      step();
      chk("t4_idle",      16'(a_state), 16'(ST_IDLE));
      step();
      chk("t4_sticky",    16'(a_err),   16'h1);
      chk("t4_no_req",    da(0) + da(1) + da(2) + da(3), 16'h0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t4_err_clr",   16'(a_err),   16'h0);

      // 5: interrupt acknowledge
      snap();
      inta_ = 1'b0; rd_ = 1'b0;
      step();
`ifdef BUS85_INTA_VEC_EN
      chk("t5_ad_oe",     16'(a_ad_oe), 16'h1);
      chk("t5_ad_o",      16'(a_ad_o),  16'hFF);
      chk("t5_ready",     16'(a_ready), 16'h1);
`else
      chk("t5_ad_oe",     16'(a_ad_oe), 16'h0);
      chk("t5_state",     16'(a_state), 16'(ST_IDLE));
`endif
      chk("t5_err",       16'(a_err),   16'h0);
      step();
      chk("t5_strobe",    16'(a_stb()), 16'h0);
      inta_ = 1'b1; rd_ = 1'b1;
      step();
      chk("t5_oe_end",    16'(a_ad_oe), 16'h0);
      chk("t5_no_req",    da(0) + da(1) + da(2) + da(3), 16'h0);

      // hold acknowledge: strobes ignored in idle
      snap();
      hlda = 1'b1; wr_ = 1'b0;
      step();
      step();
      chk("hlda_state",   16'(a_state), 16'(ST_IDLE));
      wr_ = 1'b1;
      step();
      hlda = 1'b0;
      step();
      chk("hlda_no_req",  da(0) + da(1) + da(2) + da(3), 16'h0);

      // 6: reset during a WAIT_IO=5 read on unit B
      ale = 1'b1; addrhigh = 8'h00; ad_i = 8'h44; iom_ = 1'b1;
      step();
      ale = 1'b0;
      snap();
      rd_ = 1'b0;
      step();
      step();
      step();
      chk("t6_in_wait",   16'(b_state), 16'(ST_WAIT));
      chk("t6_wait_rdy",  16'(b_ready), 16'h0);
      rst = 1'b1;
      step();
      chk("t6_rst_ready", 16'(b_ready), 16'h1);
      chk("t6_rst_state", 16'(b_state), 16'(ST_IDLE));
      chk("t6_rst_oe",    16'(b_ad_oe), 16'h0);
      chk("t6_rst_stb",   16'(b_stb()), 16'h0);
      rst = 1'b0; rd_ = 1'b1;
      step();
      step();
      chk("t6_one_req",   db(2), 16'h1);

      // ALE while busy: flag error, latch moves, read completes with the original request
      ale = 1'b1; addrhigh = 8'h10; ad_i = 8'h00; iom_ = 1'b0;
      step();
      ale = 1'b0;
      snap();
      rd_ = 1'b0;
      step();
      step();
      ale = 1'b1; addrhigh = 8'h55; ad_i = 8'h66;
      step();
      ale = 1'b0;
      chk("ale_err",      16'(a_err),   16'h1);
      chk("ale_latch",    a_mem_addr,   16'h5566);
      chk("ale_ad_o",     16'(a_ad_o),  16'h5C);
      rd_ = 1'b1;
      step();
      chk("ale_one_req",  da(0), 16'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/bus85.md
# bus85

Bus interface unit directly downstream of `core85`. It demultiplexes the 8085 AD bus using ALE and turns the RD_/WR_/IO/M_ strobes into single-cycle synchronous requests on a memory port and an I/O port. It drives read data back onto the AD bus and generates READY wait states per address space.

## Interface

**Parameters**

- `WAIT_MEM`, default 1: wait states inserted per memory access (0–15).
- `WAIT_IO`, default 2: wait states inserted per I/O access (0–15).
- `INTA_VECTOR`, default 8'hFF: opcode supplied during interrupt acknowledge (RST 7).

**Ports** (name, direction, width, meaning)

- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `ad_i` in 8: AD bus as driven by the CPU.
- `ad_o` out 8: read data toward the CPU.
- `ad_oe` out 1: `ad_o` drive enable.
- `addrhigh` in 8: A15–A8 from the CPU.
- `ale`, `rd_`, `wr_`, `iom_`, `inta_`, `hlda` in 1 each: CPU bus control.
- `ready` out 1: READY to the CPU.
- `mem_addr` out 16, `mem_wdata` out 8, `mem_rd` out 1, `mem_wr` out 1, `mem_rdata` in 8: synchronous memory. Read data is valid one cycle after `mem_rd`.
- `io_addr` out 8, `io_wdata` out 8, `io_rd` out 1, `io_wr` out 1, `io_rdata` in 8: I/O port, same timing as memory.
- `err` out 1: sticky protocol error flag.

## Operation

**Address latch**

- On every clock with `ale`=1, capture {`addrhigh`, `ad_i`} into `addr_q` and `iom_` into `iom_q`.
- `mem_addr` = `addr_q`.
- `io_addr` = `addr_q[7:0]`.

**FSM states: IDLE, STROBE, WAIT, XFER, DONE.**

- **IDLE**
  - `rd_`=0 or `wr_`=0 sampled (with `hlda`=0) → STROBE.
  - For writes, `ad_i` is registered into the write-data register.
  - Load the wait counter with `WAIT_IO` if `iom_q`=1, else `WAIT_MEM`.
- **STROBE**
  - Exactly one cycle.
  - Asserts exactly one of `mem_rd`/`mem_wr`/`io_rd`/`io_wr`, selected by `iom_q` and the strobe.
  - → WAIT if the counter is nonzero, else XFER.
- **WAIT**
  - `ready`=0.
  - Counter decrements each cycle; reaching 0 → XFER.
- **XFER**
  - Read: `ad_o` = the port read data registered in the cycle after the strobe; `ad_oe`=1.
  - Write: no bus drive.
  - Leave when `rd_` and `wr_` are both 1 → IDLE.
- **DONE**
  - Entered on error; waits for both strobes high → IDLE.

**Interrupt acknowledge**

- `inta_`=0 and `rd_`=0 are not forwarded to the ports.
- Behaviour is per Configuration; zero wait states.

**Boundary conditions**

- `rd_` and `wr_` both low in IDLE: no request, `err` set, → DONE.
- `ale`=1 while not IDLE: `err` set. The latch still updates, but the current transaction uses the request already issued.
- `hlda`=1: strobes ignored in IDLE; an in-flight transaction completes normally.
- A strobe rising early during WAIT: abort to IDLE, `ready`→1, no second request.
- Reset mid-operation: on the next edge return to IDLE. All request strobes, `ad_oe`, and `err` go to 0, and `ready`=1.

## Timing

**Reset values**

- `ready`=1, `ad_oe`=0, `ad_o`=0, all port strobes 0, `err`=0, `mem_addr`=0, `io_addr`=0, `mem_wdata`=0, `io_wdata`=0.

**Cycle numbering (strobe low sampled at edge 0)**

- Request pulse is high in cycle 1.
- `ready` is low in cycles 2 .. 1+N, where N is the selected wait count.
- Read data is registered at edge 2 and driven from cycle 2+N.
- `ad_oe` drops in the cycle after the strobe deasserts.
- Each CPU access produces exactly one request pulse, whatever its length.

## Configuration

- `BUS85_INTA_VEC_EN`
  - Defined: during `inta_`=0 with `rd_`=0, drive `INTA_VECTOR` with `ad_oe`=1, no wait states.
  - Undefined: INTA cycles are ignored entirely (`ad_oe`=0, no `err`), leaving the vector to external logic.

## Structure

- Shared package `core85_pkg`: FSM state encodings, the `RST7_OPCODE` constant (8'hFF), and the 4-bit wait-count width.
- One sub-module, `waitgen85`: loadable 4-bit down-counter with a `zero` flag, used by the WAIT state.

## Test plan

1. **Memory read:** ALE with `addrhigh`=12, `ad_i`=34, `iom_`=0, then `rd_` low, `mem_rdata`=A5. Expect one `mem_rd` pulse with `mem_addr`=1234, `ready` low for 1 cycle, then `ad_o`=A5 with `ad_oe`=1 until `rd_` rises.
2. **I/O write:** `iom_`=1, address 80, `wr_` low with `ad_i`=5A. Expect one `io_wr` pulse with `io_addr`=80 and `io_wdata`=5A, `ready` low for 2 cycles, no `mem_*` activity.
3. **`WAIT_MEM`=0 read:** expect `ready` to stay 1 throughout and `ad_o` to be valid in cycle 2.
4. **Protocol error:** `rd_` and `wr_` low together. Expect no request pulse and `err`=1, which persists until `rst`.
5. **INTA:** with `BUS85_INTA_VEC_EN`, `inta_`=0 and `rd_`=0. Expect `ad_o`=FF and no port strobe. Without the macro, expect `ad_oe`=0.
6. **Reset mid-WAIT:** assert `rst` for 1 cycle during WAIT (`WAIT_IO`=5). Expect `ready`=1 at the next edge, no further strobes, and the FSM back in IDLE.
